// File: rtl/wave_gen_pkg.sv
// Shared definitions for the wave_gen block: mode encodings and default sizes.
package wave_gen_pkg;

   typedef enum logic [1:0] {
      MODE_TRI  = 2'b00,
      MODE_SAW  = 2'b01,
      MODE_SQR  = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   localparam int WIDTH_DEF = 8;
   localparam int DIV_W_DEF = 24;

endpackage

// File: rtl/wave_gen_prescaler.sv
// wave_gen_prescaler: terminal-count divider. tick is a combinational strobe,
// high in the cycle the counter equals div, so the consumer registers its update on that edge.
module wave_gen_prescaler
   import wave_gen_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             cclk,
   input  logic             rstb,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_r;

   // A counter above a freshly lowered div simply runs on through all-ones and wraps to zero.
   assign tick = enable & (cnt_r == div);

   // Prescaler counter: cleared by reset, by disable and on terminal count.
   always_ff @(posedge cclk) begin
      if (!rstb) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (!enable) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (tick) begin
         cnt_r <= {DIV_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/wave_gen.sv
// wave_gen: prescaled triangle / sawtooth / square waveform generator (motor velocity command).
// Square mode is built only when WAVE_GEN_SQUARE_EN is defined; otherwise mode 10 runs triangle.
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             cclk,
   input  logic             rstb,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic [WIDTH-2:0] step,
   output logic [WIDTH-1:0] wave,
   output logic             dir,
   output logic             tick,
   output logic             wrap
);

   localparam int MAX_I = (2 ** (WIDTH - 1)) - 1;
   localparam int MIN_I = -(2 ** (WIDTH - 1));
   localparam logic signed [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX_I);
   localparam logic signed [WIDTH:0] MIN_X = (WIDTH + 1)'(MIN_I);
   localparam logic [WIDTH-1:0]      MAX_W = WIDTH'(MAX_I);
   localparam logic [WIDTH-1:0]      MIN_W = WIDTH'(MIN_I);

   logic                    pre_tick_s;
   mode_e                   mode_s;
   logic [WIDTH-1:0]        wave_r;
   logic                    dir_r;
   logic                    tick_r;
   logic                    wrap_r;
   logic signed [WIDTH:0]   wave_x_s;
   logic signed [WIDTH:0]   step_x_s;
   logic signed [WIDTH:0]   sum_s;
   logic signed [WIDTH:0]   diff_s;
   logic [WIDTH-1:0]        tri_wave_s;
   logic                    tri_dir_s;
   logic                    tri_wrap_s;
   logic [WIDTH-1:0]        wave_nx_s;
   logic                    dir_nx_s;
   logic                    wrap_nx_s;

   wave_gen_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .cclk   (cclk),
      .rstb   (rstb),
      .enable (enable),
      .div    (div),
      .tick   (pre_tick_s)
   );

   assign mode_s = mode_e'(mode);

   // One guard bit keeps wave +/- step exact so clamping sees the true result.
   assign wave_x_s = $signed({wave_r[WIDTH-1], wave_r});
   assign step_x_s = $signed({2'b00, step});
   assign sum_s    = wave_x_s + step_x_s;
   assign diff_s   = wave_x_s - step_x_s;

   // Triangle next state: clamp at the rails and reverse direction there.
   always_comb begin
      tri_wave_s = wave_r;
      tri_dir_s  = dir_r;
      tri_wrap_s = 1'b0;
      if (dir_r) begin
         if (sum_s >= MAX_X) begin
            tri_wave_s = MAX_W;
            tri_dir_s  = 1'b0;
         end else begin
            tri_wave_s = sum_s[WIDTH-1:0];
         end
      end else begin
         if (diff_s <= MIN_X) begin
            tri_wave_s = MIN_W;
            tri_dir_s  = 1'b1;
            tri_wrap_s = 1'b1;
         end else begin
            tri_wave_s = diff_s[WIDTH-1:0];
         end
      end
   end

   // Mode select for the value loaded on the next tick.
   always_comb begin
      wave_nx_s = wave_r;
      dir_nx_s  = dir_r;
      wrap_nx_s = 1'b0;
      case (mode_s)
         MODE_TRI: begin
            wave_nx_s = tri_wave_s;
            dir_nx_s  = tri_dir_s;
            wrap_nx_s = tri_wrap_s;
         end
         MODE_SAW: begin
            dir_nx_s = 1'b1;
            if (sum_s > MAX_X) begin
               wave_nx_s = MIN_W;
               wrap_nx_s = 1'b1;
            end else begin
               wave_nx_s = sum_s[WIDTH-1:0];
            end
         end
         MODE_SQR: begin
`ifdef WAVE_GEN_SQUARE_EN
            wave_nx_s = dir_r ? MAX_W : MIN_W;
            dir_nx_s  = ~dir_r;
            wrap_nx_s = ~dir_r;
`else
            wave_nx_s = tri_wave_s;
            dir_nx_s  = tri_dir_s;
            wrap_nx_s = tri_wrap_s;
`endif
         end
         MODE_HOLD: begin
            wave_nx_s = wave_r;
            dir_nx_s  = dir_r;
            wrap_nx_s = 1'b0;
         end
         default: begin
            wave_nx_s = wave_r;
            dir_nx_s  = dir_r;
            wrap_nx_s = 1'b0;
         end
      endcase
   end

   // Output registers: waveform, direction and pulses all load on the tick edge.
   always_ff @(posedge cclk) begin
      if (!rstb) begin
         wave_r <= {WIDTH{1'b0}};
         dir_r  <= 1'b1;
         tick_r <= 1'b0;
         wrap_r <= 1'b0;
      end else if (pre_tick_s) begin
         wave_r <= wave_nx_s;
         dir_r  <= dir_nx_s;
         tick_r <= 1'b1;
         wrap_r <= wrap_nx_s;
      end else begin
         tick_r <= 1'b0;
         wrap_r <= 1'b0;
      end
   end

   assign wave = wave_r;
   assign dir  = dir_r;
   assign tick = tick_r;
   assign wrap = wrap_r;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: directed scenarios plus randomized segments,
// every cycle compared against an integer reference model of the waveform rules.
module tb_wave_gen;

   localparam int W    = 8;
   localparam int DW   = 24;
   localparam int MAXV = (1 << (W - 1)) - 1;
   localparam int MINV = -(1 << (W - 1));

   logic          cclk;
   logic          rstb;
   logic          enable;
   logic [1:0]    mode;
   logic [DW-1:0] div;
   logic [W-2:0]  step;
   logic [W-1:0]  wave;
   logic          dir;
   logic          tick;
   logic          wrap;

   int n_checks = 0;
   int n_err    = 0;

   int m_cnt;
   int m_wave;
   int m_dir;
   int m_tick;
   int m_wrap;

   wave_gen #(
      .WIDTH (W),
      .DIV_W (DW)
   ) dut (
      .cclk   (cclk),
      .rstb   (rstb),
      .enable (enable),
      .mode   (mode),
      .div    (div),
      .step   (step),
      .wave   (wave),
      .dir    (dir),
      .tick   (tick),
      .wrap   (wrap)
   );

   initial begin
      cclk = 1'b0;
      forever #5 cclk = ~cclk;
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waveform rule applied on a tick, in plain integer arithmetic.
   function automatic void model_wave();
      int md;
      int s;
      md = int'(mode);
`ifndef WAVE_GEN_SQUARE_EN
      if (md == 2) md = 0;
`endif
      m_wrap = 0;
      if (md == 0) begin
         if (m_dir == 1) begin
            s = m_wave + int'(step);
            if (s >= MAXV) begin m_wave = MAXV; m_dir = 0; end
            else m_wave = s;
         end else begin
            s = m_wave - int'(step);
            if (s <= MINV) begin m_wave = MINV; m_dir = 1; m_wrap = 1; end
            else m_wave = s;
         end
      end else if (md == 1) begin
         m_dir = 1;
         s = m_wave + int'(step);
         if (s > MAXV) begin m_wave = MINV; m_wrap = 1; end
         else m_wave = s;
      end else if (md == 2) begin
         m_wrap = (m_dir == 0) ? 1 : 0;
         m_wave = (m_dir == 1) ? MAXV : MINV;
         m_dir  = 1 - m_dir;
      end
   endfunction

   function automatic void model_edge();
      if (!rstb) begin
         m_cnt = 0; m_wave = 0; m_dir = 1; m_tick = 0; m_wrap = 0;
      end else if (!enable) begin
         m_cnt = 0; m_tick = 0; m_wrap = 0;
      end else if (m_cnt == int'(div)) begin
         m_cnt = 0; m_tick = 1;
         model_wave();
      end else begin
         m_cnt = (m_cnt + 1) % (1 << DW);
         m_tick = 0; m_wrap = 0;
      end
   endfunction

   task automatic cyc();
      @(posedge cclk);
      model_edge();
      #1;
      chk("wave", $signed(wave), m_wave);
      chk("dir", {31'd0, dir}, m_dir);
      chk("tick", {31'd0, tick}, m_tick);
      chk("wrap", {31'd0, wrap}, m_wrap);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (tick !== 1'b1 && n < 64);
      if (tick !== 1'b1) begin
         n_checks++;
         n_err++;
         $error("FAIL tick_timeout: no tick within %0d cycles", n);
      end
   endtask

   task automatic run_ticks(input int k);
      int n;
      for (int i = 0; i < k; i++) wait_tick(n);
   endtask

   initial begin
      int n;
      int held;
      int sq_wave[3];
      int sq_wrap[3];
`ifdef WAVE_GEN_SQUARE_EN
      sq_wave = '{MAXV, MINV, MAXV};
      sq_wrap = '{0, 1, 0};
`else
      sq_wave = '{1, 2, 3};
      sq_wrap = '{0, 0, 0};
`endif
      m_cnt = 0; m_wave = 0; m_dir = 1; m_tick = 0; m_wrap = 0;
      rstb = 1'b0; enable = 1'b0; mode = 2'b00; div = 24'd3; step = 7'd1;
      cyc();
      cyc();
      chk("reset_wave", $signed(wave), 0);
      chk("reset_dir", {31'd0, dir}, 1);
      chk("reset_tick", {31'd0, tick}, 0);

      // Triangle ramp, div=3, step=1.
      rstb = 1'b1; enable = 1'b1;
      wait_tick(n);
      chk("first_tick_latency", n, 4);
      chk("first_wave", $signed(wave), 1);
      run_ticks(126);
      chk("tri_top_wave", $signed(wave), MAXV);
      chk("tri_top_dir", {31'd0, dir}, 0);
      run_ticks(1);
      chk("tri_after_top", $signed(wave), 126);
      run_ticks(254);
      chk("tri_bottom_wave", $signed(wave), MINV);
      chk("tri_bottom_wrap", {31'd0, wrap}, 1);
      chk("tri_bottom_dir", {31'd0, dir}, 1);
      run_ticks(1);
      chk("tri_after_bottom", $signed(wave), -127);

      // Clamp from 120 with a large step.
      div = 24'd0;
      run_ticks(247);
      chk("tri_120", $signed(wave), 120);
      step = 7'd10;
      run_ticks(1);
      chk("clamp_wave", $signed(wave), MAXV);
      chk("clamp_dir", {31'd0, dir}, 0);

      // Sawtooth wrap.
      rstb = 1'b0;
      cyc();
      rstb = 1'b1; mode = 2'b01; div = 24'd0; step = 7'd100;
      wait_tick(n);
      chk("saw_first_latency", n, 1);
      chk("saw_100", $signed(wave), 100);
      run_ticks(1);
      chk("saw_wrap_wave", $signed(wave), MINV);
      chk("saw_wrap_pulse", {31'd0, wrap}, 1);
      run_ticks(1);
      chk("saw_minus28", $signed(wave), -28);

      // step=0 at MAX flips direction only.
      rstb = 1'b0;
      cyc();
      rstb = 1'b1; step = 7'd127;
      run_ticks(1);
      chk("saw_127", $signed(wave), MAXV);
      mode = 2'b00; step = 7'd0;
      run_ticks(1);
      chk("step0_dir", {31'd0, dir}, 0);
      chk("step0_wave", $signed(wave), MAXV);

      // Disable freeze, then reset with enable high.
      rstb = 1'b0;
      cyc();
      rstb = 1'b1; div = 24'd5; step = 7'd3;
      for (int i = 0; i < 14; i++) cyc();
      held = m_wave;
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("frozen_wave", $signed(wave), held);
      end
      chk("frozen_value", held, 6);
      enable = 1'b1; rstb = 1'b0;
      cyc();
      chk("rst_mid_wave", $signed(wave), 0);
      chk("rst_mid_dir", {31'd0, dir}, 1);
      rstb = 1'b1;
      wait_tick(n);
      chk("rst_release_latency", n, 6);

      // Mode 10: square when built in, otherwise triangle.
      rstb = 1'b0;
      cyc();
      rstb = 1'b1; mode = 2'b10; div = 24'd1; step = 7'd1;
      for (int i = 0; i < 3; i++) begin
         wait_tick(n);
         chk("sqr_spacing", n, 2);
         chk("sqr_wave", $signed(wave), sq_wave[i]);
         chk("sqr_wrap", {31'd0, wrap}, sq_wrap[i]);
      end

      // Hold: ticks continue, waveform frozen.
      mode = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_tick(n);
         chk("hold_spacing", n, 2);
         chk("hold_wave", $signed(wave), sq_wave[2]);
         chk("hold_wrap", {31'd0, wrap}, 0);
      end

      // Randomized segments; div only changes while the counter is cleared.
      for (int s = 0; s < 60; s++) begin
         int len;
         enable = 1'b0;
         cyc();
         mode   = 2'($urandom_range(0, 3));
         div    = DW'($urandom_range(0, 3));
         step   = 7'($urandom_range(0, 127));
         enable = 1'b1;
         if ($urandom_range(0, 9) == 0) rstb = 1'b0;
         len = $urandom_range(5, 40);
         for (int c = 0; c < len; c++) begin
            cyc();
            rstb = 1'b1;
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) step = 7'($urandom_range(0, 127));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
